// File: rtl/xpmwrap_tdpram_be.sv
// Single-clock true-dual-port RAM with byte enables, a configurable read pipeline,
// cross-port collision detection and a post-reset clear sequencer.
module xpmwrap_tdpram_be #(
   parameter int ADDR_WIDTH     = 6,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_WIDTH     = 8,
   parameter int READ_LATENCY   = 2,
   parameter int WRITE_MODE     = 0,
   parameter int CLEAR_ON_RESET = 1,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             ena,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wea,
   input  logic [ADDR_WIDTH-1:0]            addra,
   input  logic [DATA_WIDTH-1:0]            dina,
   output logic [DATA_WIDTH-1:0]            douta,
   output logic                             douta_valid,
   input  logic                             enb,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] web,
   input  logic [ADDR_WIDTH-1:0]            addrb,
   input  logic [DATA_WIDTH-1:0]            dinb,
   output logic [DATA_WIDTH-1:0]            doutb,
   output logic                             doutb_valid,
   output logic                             init_busy,
   output logic                             collision,
   output logic [CNT_WIDTH-1:0]             collision_count
);

   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [DATA_WIDTH-1:0] word_t;
   typedef logic [NB-1:0]         be_t;
   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t state, state_nxt;
   addr_t  clr_ptr, clr_ptr_nxt;
   logic   init_busy_nxt;
   logic   ready;

   word_t  mem [DEPTH];

   // Index 0 is port A, index 1 is port B.
   logic   p_act  [2];
   be_t    p_we   [2];
   addr_t  p_addr [2];
   word_t  p_din  [2];
   word_t  p_rd   [2];
   logic   coll_nxt;

   word_t                   pipe_d [2][READ_LATENCY];
   logic [READ_LATENCY-1:0] pipe_v [2];

   function automatic word_t merge(input word_t old_w, input word_t new_w, input be_t be);
      word_t res;
      res = old_w;
      for (int i = 0; i < NB; i++)
         if (be[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
      return res;
   endfunction

   // ---------------------------------------------------------------- clear FSM
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_ptr   <= '0;
         init_busy <= (CLEAR_ON_RESET != 0);
      end else begin
         state     <= state_nxt;
         clr_ptr   <= clr_ptr_nxt;
         init_busy <= init_busy_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt     = state;
      clr_ptr_nxt   = clr_ptr;
      init_busy_nxt = init_busy;
      unique case (state)
         ST_CLEAR: begin
            clr_ptr_nxt = clr_ptr + addr_t'(1);
            if (clr_ptr == addr_t'(DEPTH - 1)) begin
               state_nxt     = ST_READY;
               init_busy_nxt = 1'b0;
               clr_ptr_nxt   = '0;
            end
         end
         ST_READY: init_busy_nxt = 1'b0;
         default:  state_nxt     = ST_READY;
      endcase
   end

   assign ready = (state == ST_READY);

   // ------------------------------------------------------------ port requests
   always_comb begin
      p_act[0]  = ready & ena;
      p_act[1]  = ready & enb;
      p_addr[0] = addra;
      p_addr[1] = addrb;
      p_din[0]  = dina;
      p_din[1]  = dinb;
      p_we[0]   = p_act[0] ? wea : '0;
      p_we[1]   = p_act[1] ? web : '0;
      // Only a port's own write is ever forwarded; the other port's write is never visible.
      for (int p = 0; p < 2; p++)
         p_rd[p] = (WRITE_MODE != 0) ? merge(mem[p_addr[p]], p_din[p], p_we[p])
                                     : mem[p_addr[p]];
      coll_nxt = p_act[0] & p_act[1] & (addra == addrb) & ((|p_we[0]) | (|p_we[1]));
   end

   // -------------------------------------------------------------- storage array
   // NOTE: the array has no reset so it maps onto block RAM; the clear FSM zeroes it instead.
   always_ff @(posedge clk) begin
      if (!ready) begin
         mem[clr_ptr] <= '0;
      end else begin
         // Port B is issued first so port A's lanes are the last assignment and win.
         for (int p = 1; p >= 0; p--)
            for (int i = 0; i < NB; i++)
               if (p_we[p][i])
                  mem[p_addr[p]][i*BYTE_WIDTH +: BYTE_WIDTH] <= p_din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   // ------------------------------------------------------------- read pipeline
   // Data stages only advance behind a valid, so the last stage holds between strobes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int p = 0; p < 2; p++) begin
            pipe_v[p] <= '0;
            for (int s = 0; s < READ_LATENCY; s++) pipe_d[p][s] <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            pipe_v[p][0] <= p_act[p];
            if (p_act[p]) pipe_d[p][0] <= p_rd[p];
            for (int s = 1; s < READ_LATENCY; s++) begin
               pipe_v[p][s] <= pipe_v[p][s-1];
               if (pipe_v[p][s-1]) pipe_d[p][s] <= pipe_d[p][s-1];
            end
         end
      end
   end

   assign douta       = pipe_d[0][READ_LATENCY-1];
   assign douta_valid = pipe_v[0][READ_LATENCY-1];
   assign doutb       = pipe_d[1][READ_LATENCY-1];
   assign doutb_valid = pipe_v[1][READ_LATENCY-1];

   // ------------------------------------------------------- collision tracking
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         collision       <= 1'b0;
         collision_count <= '0;
      end else begin
         collision <= coll_nxt;
         if (coll_nxt && (collision_count != '1))
            collision_count <= collision_count + CNT_WIDTH'(1);
      end
   end

endmodule
